ir_nec_tx: RTL and testbench
============================

// Module: ir_nec_tx
// PURPOSE
//  NEC-protocol IR frame transmitter. It accepts an 8-bit address and an 8-bit command over a valid/ready handshake.
//  It generates the NEC mark/space envelope and gates the free-running 38 kHz carrier from the IR carrier generator with it.
//  Sits directly downstream of the carrier generator; ir_out drives the IR LED pad.
// PARAMETERS
//  CLOCK_SPEED  8000000  system clock in Hz
//  GAP_UNITS    72       idle guard after stop mark, in 562.5 us units (72 = 40.5 ms)
//  derived: UNIT_CYCLES = CLOCK_SPEED*9/16000 (562.5 us; 4500 at 8 MHz)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  addr        in   8  NEC address; sampled on accept
//  cmd         in   8  NEC command; sampled on accept
//  valid       in   1  request to send one frame
//  ready       out  1  block idle, can accept a frame
//  busy        out  1  frame or guard gap in progress (= ~ready)
//  carrier_in  in   1  38 kHz square wave from the carrier generator
//  envelope    out  1  registered NEC envelope (1 = mark)
//  ir_out      out  1  envelope & carrier_in (combinational AND)
// BEHAVIOUR
//  Reset: state IDLE; ready=1, busy=0, envelope=0 (so ir_out=0); all counters 0. Reset is async and may occur mid-frame.
//  Unit timer: counts 0..UNIT_CYCLES-1 and pulses unit_tick on the wrap. It is cleared on accept, so the first unit is exactly UNIT_CYCLES clocks.
//  Accept: valid & ready in IDLE.
//   - Latch shift reg = {~cmd, cmd, ~addr, addr} (32 b).
//   - Next cycle: state LEAD_MARK, envelope=1, ready=0.
//   - valid outside IDLE is ignored; addr/cmd may change freely after accept.
//  States (duration in units; envelope value):
//   IDLE        -;  0       accept -> LEAD_MARK
//   LEAD_MARK   16; 1       -> LEAD_SPACE
//   LEAD_SPACE  8;  0       -> BIT_MARK
//   BIT_MARK    1;  1       -> BIT_SPACE
//   BIT_SPACE   1 if bit=0, 3 if bit=1; 0.
//               Shift right, bit_cnt++. bit_cnt==31 at end -> STOP_MARK, else -> BIT_MARK.
//   STOP_MARK   1;  1       -> GAP
//   GAP         GAP_UNITS; 0   -> IDLE (ready=1 the cycle after the last unit_tick)
//  Bit order: LSB first; addr, ~addr, cmd, ~cmd.
//  Transitions: each state's duration counter advances on unit_tick. The state and envelope change on the same edge as the final tick of the state.
//  Envelope edges are therefore exact multiples of UNIT_CYCLES from the accept edge+1; no jitter.
//  Carrier is not resynchronised. ir_out simply ANDs the envelope with carrier_in, so partial carrier half-periods at mark edges are allowed.
//  Frame length: 16+8 units, plus 2 units per 0-bit and 4 units per 1-bit, plus 1 stop unit.
//  Counters: bit_cnt 5 b; state duration counter 7 b (max of 16, 3, GAP_UNITS; GAP_UNITS <= 127); unit timer $clog2(UNIT_CYCLES) b.
//   No wrap occurs in legal operation.
//  Repeat codes are not generated; back-to-back frames are separated by at least GAP_UNITS.
//  valid held high continuously: frames are re-accepted on the first cycle ready=1.
// TESTING (CLOCK_SPEED=8000000, unit=4500 clk; carrier_in driven by a 105-clk toggle model)
//  1. Reset mid LEAD_MARK (assert at 30000 clk after accept).
//     -> envelope/ir_out 0 within the same cycle; ready=1 after release; next accept restarts cleanly.
//  2. addr=0x00 cmd=0xFF, valid one cycle.
//     -> envelope high 72000 clk, low 36000, then 32 bits as 0x00,0xFF,0xFF,0x00 LSB first, stop mark 4500.
//     -> Total 121 units = 544500 clk; ready returns 324000 clk later.
//  3. addr=0x5A cmd=0x3C.
//     -> decoder model recovers addr 0x5A, ~addr 0xA5, cmd 0x3C, ~cmd 0xC3.
//     -> Space widths exactly 4500 (0) or 13500 (1) clk.
//  4. valid pulsed during BIT_SPACE and GAP -> ignored; frame unchanged; ready stays 0 until GAP ends.
//  5. valid held high for 3 frames -> each accept is exactly 1 clk after ready rises; inter-frame idle >= 324000 clk.
//  6. Every cycle: ir_out == envelope & carrier_in, and ir_out == 0 whenever envelope == 0.

Source files
------------

// File: rtl/ir_nec_tx_if.sv
// NEC transmitter request channel: address/command payload plus valid/ready handshake.
// No latency of its own; pure wiring bundle.
// The slave lowers ready while a frame or guard gap is in progress; the master holds valid until ready.
interface ir_nec_tx_if;
   logic [7:0] addr;
   logic [7:0] cmd;
   logic       valid;
   logic       ready;
   logic       busy;

   modport master (output addr, output cmd, output valid, input ready, input busy);
   modport slave  (input addr, input cmd, input valid, output ready, output busy);
endinterface

// File: rtl/ir_nec_tx.sv
// NEC IR frame transmitter: builds the mark/space envelope and gates the external 38 kHz carrier with it.
// Envelope rises one clock after accept; every later edge lands on an exact multiple of UNIT_CYCLES.
// ready is low from accept until the guard gap has fully elapsed; valid outside IDLE is ignored.
module ir_nec_tx #(
   parameter int CLOCK_SPEED = 8000000,
   parameter int GAP_UNITS   = 72
) (
   input  logic         clk,
   input  logic         rst,
   ir_nec_tx_if.slave   tx,
   input  logic         carrier_in_i,
   output logic         envelope_o,
   output logic         ir_out_o
);

   // One NEC unit is 562.5 us.
   localparam int UNIT_CYCLES = CLOCK_SPEED * 9 / 16000;
   localparam int TW          = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

   localparam logic [TW-1:0] TMR_LAST       = TW'(UNIT_CYCLES - 1);
   localparam logic [6:0]    LEAD_MARK_LAST  = 7'd15;
   localparam logic [6:0]    LEAD_SPACE_LAST = 7'd7;
   localparam logic [6:0]    ONE_SPACE_LAST  = 7'd2;
   localparam logic [6:0]    GAP_LAST        = 7'(GAP_UNITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD_MARK,
      S_LEAD_SPACE,
      S_BIT_MARK,
      S_BIT_SPACE,
      S_STOP_MARK,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [6:0]    dur_q, dur_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [31:0]   shift_q, shift_d;
   logic          env_q, env_d;

   logic          accept;
   logic          unit_tick;
   logic [6:0]    dur_last;
   logic          dur_done;

   // State, timers and payload registers; reset may strike mid-frame and drops the envelope at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         tmr_q     <= '0;
         dur_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         env_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         dur_q     <= dur_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         env_q     <= env_d;
      end
   end

   // Next-state: unit timer, per-state unit counter, bit shifting and the registered envelope.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      dur_d     = dur_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      env_d     = env_q;
      dur_last  = 7'd0;

      accept    = tx.valid && (state_q == S_IDLE);
      unit_tick = (state_q != S_IDLE) && (tmr_q == TMR_LAST);

      // The timer idles at zero and restarts from zero on accept, so the first unit is full length.
      if (accept) begin
         tmr_d = '0;
      end else if (state_q != S_IDLE) begin
         tmr_d = unit_tick ? '0 : tmr_q + TW'(1);
      end

      // Length of the current state, expressed as its last unit index.
      case (state_q)
         S_LEAD_MARK:  dur_last = LEAD_MARK_LAST;
         S_LEAD_SPACE: dur_last = LEAD_SPACE_LAST;
         S_BIT_SPACE:  dur_last = shift_q[0] ? ONE_SPACE_LAST : 7'd0;
         S_GAP:        dur_last = GAP_LAST;
         default:      dur_last = 7'd0;
      endcase
      dur_done = unit_tick && (dur_q == dur_last);

      if (unit_tick) begin
         dur_d = dur_done ? 7'd0 : dur_q + 7'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // Transmitted LSB first: addr, ~addr, cmd, ~cmd.
               shift_d   = {~tx.cmd, tx.cmd, ~tx.addr, tx.addr};
               bit_cnt_d = 5'd0;
               dur_d     = 7'd0;
               state_d   = S_LEAD_MARK;
            end
         end
         S_LEAD_MARK:  if (dur_done) state_d = S_LEAD_SPACE;
         S_LEAD_SPACE: if (dur_done) state_d = S_BIT_MARK;
         S_BIT_MARK:   if (dur_done) state_d = S_BIT_SPACE;
         S_BIT_SPACE: begin
            if (dur_done) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 5'd1;
               state_d   = (bit_cnt_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end
         end
         S_STOP_MARK:  if (dur_done) state_d = S_GAP;
         S_GAP:        if (dur_done) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase

      // Envelope follows the state being entered, so both change on the same edge.
      env_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) || (state_d == S_STOP_MARK);
   end

   assign tx.ready   = (state_q == S_IDLE);
   assign tx.busy    = ~tx.ready;
   assign envelope_o = env_q;
   // Carrier is not resynchronised; partial half-periods at mark edges are acceptable.
   assign ir_out_o   = env_q & carrier_in_i;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx at a scaled-down clock (9 clocks per NEC unit).
// Each frame is compared segment by segment against a unit list built from the NEC rules.
// Randomised payloads, valid noise during a frame, held valid and a mid-frame reset are exercised.
module tb_ir_nec_tx;

   localparam int CLK_HZ = 16000;
   localparam int GAP    = 72;
   localparam int UNIT   = CLK_HZ * 9 / 16000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic carrier = 1'b0;
   int   car_cnt = 0;
   logic envelope;
   logic ir_out;

   int n_chk  = 0;
   int n_fail = 0;

   int exp_units[$];

   ir_nec_tx_if bus ();

   ir_nec_tx #(.CLOCK_SPEED(CLK_HZ), .GAP_UNITS(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx           (bus),
      .carrier_in_i (carrier),
      .envelope_o   (envelope),
      .ir_out_o     (ir_out)
   );

   always #5 clk = ~clk;

   // Free-running carrier stand-in, unrelated in phase to frame timing.
   always @(posedge clk) begin
      if (car_cnt == 2) begin
         car_cnt <= 0;
         carrier <= ~carrier;
      end else begin
         car_cnt <= car_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Continuous output relations.
   always @(negedge clk) begin
      chk("ir_out_gate", {31'b0, ir_out}, {31'b0, envelope & carrier});
      chk("busy_inv", {31'b0, bus.busy}, {31'b0, ~bus.ready});
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: alternating mark/space durations in units, starting with the leader mark.
   task automatic build_ref(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] bytes [4];
      bytes[0] = a;
      bytes[1] = ~a;
      bytes[2] = c;
      bytes[3] = ~c;
      exp_units.delete();
      exp_units.push_back(16);
      exp_units.push_back(8);
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            exp_units.push_back(1);
            exp_units.push_back(bytes[b][i] ? 3 : 1);
         end
      end
      exp_units.push_back(1);
   endtask

   // Count negedges while envelope stays at lvl; optionally toggle valid randomly meanwhile.
   task automatic measure_run(input logic lvl, input int limit, input bit noise, output int n);
      n = 0;
      while (envelope === lvl && n < limit) begin
         if (noise) bus.valid = (n + 2 < limit) ? 1'($urandom_range(0, 1)) : 1'b0;
         n++;
         @(negedge clk);
      end
      if (noise) bus.valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input bit hold, input bit noise);
      int n;
      logic [31:0] word;
      bit was_held;
      was_held = (bus.valid === 1'b1);
      n = 0;
      while (bus.ready !== 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
      chk("ready_wait", {31'b0, n < 5000}, 32'd1);
      if (was_held) chk("accept_lat", n, 0);
      bus.addr  = a;
      bus.cmd   = c;
      bus.valid = 1'b1;
      build_ref(a, c);
      @(posedge clk);
      #1;
      if (!hold) bus.valid = 1'b0;
      bus.addr = 8'($urandom);
      bus.cmd  = 8'($urandom);
      @(negedge clk);
      chk("accepted", {30'b0, bus.ready, envelope}, 32'b01);
      word = '0;
      for (int i = 0; i < exp_units.size(); i++) begin
         measure_run((i % 2) == 0, exp_units[i] * UNIT + 4, noise, n);
         chk($sformatf("seg%0d", i), n, exp_units[i] * UNIT);
         if (i >= 3 && (i % 2) == 1) word[(i - 3) / 2] = (n > 2 * UNIT);
      end
      chk("decoded", word, {~c, c, ~a, a});
      n = 0;
      while (bus.ready === 1'b0 && n < GAP * UNIT + 4) begin
         if (noise) bus.valid = (n + 2 < GAP * UNIT + 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         n++;
         @(negedge clk);
      end
      bus.valid = hold;
      chk("gap_len", n, GAP * UNIT);
      chk("idle_env", {31'b0, envelope}, 32'd0);
   endtask

   initial begin
      int n;
      bus.valid = 1'b0;
      bus.addr  = 8'h00;
      bus.cmd   = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, bus.ready}, 32'd1);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_env", {31'b0, envelope}, 32'd0);
      chk("rst_irout", {31'b0, ir_out}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of the leader mark.
      bus.addr  = 8'($urandom);
      bus.cmd   = 8'($urandom);
      bus.valid = 1'b1;
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      n = 0;
      repeat (6 * UNIT + 6) @(negedge clk);
      chk("pre_rst_env", {31'b0, envelope}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_env", {31'b0, envelope}, 32'd0);
      chk("midrst_irout", {31'b0, ir_out}, 32'd0);
      chk("midrst_ready", {31'b0, bus.ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", {31'b0, bus.ready}, 32'd1);

      send_frame(8'h00, 8'hFF, 1'b0, 1'b0);
      send_frame(8'h5A, 8'h3C, 1'b0, 1'b0);
      send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b1);
      send_frame(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      send_frame(8'($urandom), 8'($urandom), 1'b1, 1'b0);
      send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0);
      send_frame(8'($urandom), 8'($urandom), 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
